// File: rtl/tpu_pkg.sv
// tpu_pkg: shared definitions for the TPU datapath blocks.
//   state_e           - readout FSM states (IDLE waits for a tile, SEND drains it)
//   DEFAULT_N_LANES   - default number of MAC lanes per tile
//   DEFAULT_OUT_WIDTH - default width of each lane sum
package tpu_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  localparam int DEFAULT_N_LANES   = 4;
  localparam int DEFAULT_OUT_WIDTH = 8;

endpackage

// File: rtl/register.sv
// register: generic WIDTH-bit storage register with write enable.
//   clk - rising-edge clock
//   rst - asynchronous active-high reset, clears q to 0
//   en  - load d into the register on the next edge
//   d   - data to load
//   q   - stored value
module register #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (en) begin
      q_d = d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/mac_readout.sv
// mac_readout: snapshots the MAC lane accumulators when a tile finishes and
// streams them out one lane per valid/ready transfer.
//   clk, rst   - clock and asynchronous active-high reset
//   done_in    - one-cycle pulse: lane accumulation for the tile is complete
//   sums       - packed lane sums, lane i at sums[i*OUT_WIDTH +: OUT_WIDTH]
//   mac_clr    - one-cycle pulse after capture telling the lanes to clear
//   busy       - a snapshot is held or being sent
//   out_valid/out_ready/out_data/out_idx/out_last - output word stream
//   overrun    - sticky flag: done_in arrived while busy
module mac_readout
  import tpu_pkg::*;
#(
  parameter int N_LANES   = DEFAULT_N_LANES,
  parameter int OUT_WIDTH = DEFAULT_OUT_WIDTH,
  localparam int IDX_W    = (N_LANES > 1) ? $clog2(N_LANES) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         done_in,
  input  logic [N_LANES*OUT_WIDTH-1:0] sums,
  output logic                         mac_clr,
  output logic                         busy,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OUT_WIDTH-1:0]         out_data,
  output logic [IDX_W-1:0]             out_idx,
  output logic                         out_last,
  output logic                         overrun
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_LANES - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             mac_clr_q, mac_clr_d;
  logic             overrun_q, overrun_d;
  logic             capture;

  logic [OUT_WIDTH-1:0] shadow [N_LANES];

  // Shadow bank: each lane is loaded only on the capture edge, so later
  // changes on sums cannot disturb a tile that is being drained.
  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    register #(.WIDTH(OUT_WIDTH)) u_lane (
      .clk (clk),
      .rst (rst),
      .en  (capture),
      .d   (sums[i*OUT_WIDTH +: OUT_WIDTH]),
      .q   (shadow[i])
    );
  end

  // Next-state logic. done_in is only honoured in IDLE; in SEND (including
  // the edge of the final transfer) it just raises the sticky overrun flag.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    mac_clr_d = 1'b0;
    overrun_d = overrun_q;
    capture   = 1'b0;
    case (state_q)
      IDLE: begin
        if (done_in) begin
          capture   = 1'b1;
          mac_clr_d = 1'b1;
          idx_d     = '0;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (done_in) begin
          overrun_d = 1'b1;
        end
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      mac_clr_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      mac_clr_q <= mac_clr_d;
      overrun_q <= overrun_d;
    end
  end

  // Outputs come straight from registered state, so out_valid never depends
  // on out_ready within the same cycle.
  assign busy      = (state_q == SEND);
  assign out_valid = (state_q == SEND);
  assign out_data  = shadow[idx_q];
  assign out_idx   = idx_q;
  assign out_last  = (state_q == SEND) && (idx_q == LAST_IDX);
  assign mac_clr   = mac_clr_q;
  assign overrun   = overrun_q;

endmodule
